ifetch_ctrl: RTL

//  Fetch sequencer for the instruction memory. Owns the PC and drives read_address.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_buf2.sv | 50 +++++
 rtl/ifetch_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data width, fetch FSM
// states and the {pc, instr} packet passed from fetch to decode.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HALT  = 2'd2
  } ifetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry FIFO of fetch packets; head is read combinationally.
// Ports: clk, rst, push/din, pop, flush, count_o, valid_o, head_o.
module fetch_buf2
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  fetch_pkt_t din_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic [1:0] count_o,
  output logic       valid_o,
  output fetch_pkt_t head_o
);

  fetch_pkt_t ent_q [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;

  assign count_o = cnt_q;
  assign valid_o = (cnt_q != 2'd0);
  assign head_o  = ent_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      // Entries are kept so the head stays held while empty.
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) begin
        ent_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (pop_i) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the PC, reads instruction memory and
// buffers {pc, instr} for decode over valid/ready.
// Ports: clk, rst, start, read_address/instruction (imem),
// redirect_valid/target, out_valid/ready/instr/pc, halted, busy.
module ifetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned     MEM_BYTES    = 64,
  parameter bit              HALT_ON_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [XLEN-1:0] read_address,
  input  logic [XLEN-1:0] instruction,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            halted,
  output logic            busy
);

  localparam logic [XLEN-1:0] PC_MASK = XLEN'(MEM_BYTES - 1);

  ifetch_state_e   state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic       push;
  logic       pop;
  logic       flush;
  logic [1:0] count;
  fetch_pkt_t head;
  fetch_pkt_t pkt;

  assign pop = out_valid && out_ready;
  assign pkt = '{pc: pc_q, instr: instruction};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = {redirect_target[XLEN-1:2], 2'b00} & PC_MASK;
      // From IDLE a redirect only retargets the PC.
      if (state_q != IF_IDLE) state_d = IF_FETCH;
    end else begin
      unique case (1'b1)
        (state_q == IF_IDLE): begin
          if (start) state_d = IF_FETCH;
        end
        (state_q == IF_FETCH): begin
          if (count < 2'd2 || pop) begin
            // The zero word is dropped and the PC parks on it.
            if (HALT_ON_ZERO && instruction == '0) begin
              state_d = IF_HALT;
            end else begin
              push = 1'b1;
              pc_d = (pc_q + XLEN'(4)) & PC_MASK;
            end
          end
        end
        (state_q == IF_HALT): begin
          state_d = IF_HALT;
        end
        default: state_d = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IF_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buf2 u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (pkt),
    .pop_i   (pop),
    .flush_i (flush),
    .count_o (count),
    .valid_o (out_valid),
    .head_o  (head)
  );

  assign read_address = pc_q;
  assign out_instr    = head.instr;
  assign out_pc       = head.pc;
  assign halted       = (state_q == IF_HALT);
  assign busy         = (state_q == IF_FETCH);

endmodule
